// File: rtl/spireg_bank_arb.sv
// Register bank and arbiter behind the SPI register slave.
// The bank is shared between the SPI host, which is never stalled, and an
// on-chip core port using a req/gnt handshake. The block also decodes the
// slave's fast commands and builds the status byte returned to the host.
//
// Ports:
//   clk, nrst                         clock, asynchronous active-low reset
//   spi_addr/spi_wdata/spi_wvld       SPI register write port
//   spi_rdata                         bank[spi_addr], registered
//   fastcmd/fastcmd_vld               fast command strobe from the slave
//   status                            {busy, lock, err, core_wait, wr_cnt}, registered
//   core_req/core_we/core_addr/core_wdata   core request, held until granted
//   core_gnt                          combinational grant
//   core_rdata/core_rvalid/core_err   core read data, read-valid and locked-write pulses
//   usr_cmd/usr_cmd_vld               forwarded fast command and its pulse
module spireg_bank_arb #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned REG_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [REG_W-1:0]  spi_wdata,
  input  logic              spi_wvld,
  output logic [REG_W-1:0]  spi_rdata,
  input  logic [5:0]        fastcmd,
  input  logic              fastcmd_vld,
  output logic [7:0]        status,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [REG_W-1:0]  core_wdata,
  output logic              core_gnt,
  output logic [REG_W-1:0]  core_rdata,
  output logic              core_rvalid,
  output logic              core_err,
  output logic [5:0]        usr_cmd,
  output logic              usr_cmd_vld
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CLR_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] CMD_CLEAR   = 6'h01;
  localparam logic [5:0] CMD_LOCK    = 6'h02;
  localparam logic [5:0] CMD_UNLOCK  = 6'h03;
  localparam logic [5:0] CMD_ERR_CLR = 6'h3F;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CLR_W-1:0]   clr_idx_q, clr_idx_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic [REG_W-1:0]   bank_q [DEPTH];

  logic               bank_we_c;
  logic [ADDR_W-1:0]  bank_waddr_c;
  logic [REG_W-1:0]   bank_wdata_c;

  logic               core_gnt_c;
  logic               cmd_clear_c, cmd_lock_c, cmd_unlock_c, cmd_err_clr_c, cmd_fwd_c;

  logic [REG_W-1:0]   spi_rdata_q, spi_rdata_d;
  logic [REG_W-1:0]   core_rdata_q, core_rdata_d;
  logic               core_rvalid_q, core_rvalid_d;
  logic               core_err_q, core_err_d;
  logic [5:0]         usr_cmd_q, usr_cmd_d;
  logic               usr_cmd_vld_q, usr_cmd_vld_d;
  logic [7:0]         status_q, status_d;

  // Fast command decode and grant
  always_comb begin
    cmd_clear_c   = fastcmd_vld && (fastcmd == CMD_CLEAR);
    cmd_lock_c    = fastcmd_vld && (fastcmd == CMD_LOCK);
    cmd_unlock_c  = fastcmd_vld && (fastcmd == CMD_UNLOCK);
    cmd_err_clr_c = fastcmd_vld && (fastcmd == CMD_ERR_CLR);
    cmd_fwd_c     = fastcmd_vld && !(cmd_clear_c || cmd_lock_c || cmd_unlock_c || cmd_err_clr_c);
    // SPI always wins; core waits while the bank is being cleared
    core_gnt_c    = core_req && !spi_wvld && (state_q == ST_IDLE);
  end

  // Next-state, single bank write port and registered-output logic
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    lock_d        = lock_q;
    err_d         = err_q;
    wr_cnt_d      = wr_cnt_q;
    bank_we_c     = 1'b0;
    bank_waddr_c  = '0;
    bank_wdata_c  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (spi_wvld) begin
          bank_we_c    = 1'b1;
          bank_waddr_c = spi_addr;
          bank_wdata_c = spi_wdata;
          wr_cnt_d     = wr_cnt_q + CNT_W'(1);
        end else if (core_gnt_c && core_we && !lock_q) begin
          bank_we_c    = 1'b1;
          bank_waddr_c = core_addr;
          bank_wdata_c = core_wdata;
        end
        // The same-cycle SPI write still commits; the sweep overwrites it later
        if (cmd_clear_c) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        bank_we_c    = 1'b1;
        bank_waddr_c = clr_idx_q[ADDR_W-1:0];
        bank_wdata_c = '0;
        if (spi_wvld) begin
          err_d = 1'b1;
        end
        if (clr_idx_q == CLR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + CLR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmd_lock_c) begin
      lock_d = 1'b1;
    end
    if (cmd_unlock_c) begin
      lock_d = 1'b0;
    end
    if (cmd_err_clr_c) begin
      err_d    = 1'b0;
      wr_cnt_d = '0;
    end

    spi_rdata_d   = bank_q[spi_addr];
    core_rdata_d  = (core_gnt_c && !core_we) ? bank_q[core_addr] : core_rdata_q;
    core_rvalid_d = core_gnt_c && !core_we;
    core_err_d    = core_gnt_c && core_we && lock_q;
    usr_cmd_d     = cmd_fwd_c ? fastcmd : usr_cmd_q;
    usr_cmd_vld_d = cmd_fwd_c;
    status_d      = {(state_q == ST_CLEAR), lock_q, err_q, core_req && !core_gnt_c, wr_cnt_q};
  end

  // Control and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      clr_idx_q     <= '0;
      lock_q        <= 1'b0;
      err_q         <= 1'b0;
      wr_cnt_q      <= '0;
      spi_rdata_q   <= '0;
      core_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      core_err_q    <= 1'b0;
      usr_cmd_q     <= '0;
      usr_cmd_vld_q <= 1'b0;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      lock_q        <= lock_d;
      err_q         <= err_d;
      wr_cnt_q      <= wr_cnt_d;
      spi_rdata_q   <= spi_rdata_d;
      core_rdata_q  <= core_rdata_d;
      core_rvalid_q <= core_rvalid_d;
      core_err_q    <= core_err_d;
      usr_cmd_q     <= usr_cmd_d;
      usr_cmd_vld_q <= usr_cmd_vld_d;
      status_q      <= status_d;
    end
  end

  // Register bank storage
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank_q[i] <= '0;
      end
    end else if (bank_we_c) begin
      bank_q[bank_waddr_c] <= bank_wdata_c;
    end
  end

  assign core_gnt    = core_gnt_c;
  assign spi_rdata   = spi_rdata_q;
  assign core_rdata  = core_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign core_err    = core_err_q;
  assign usr_cmd     = usr_cmd_q;
  assign usr_cmd_vld = usr_cmd_vld_q;
  assign status      = status_q;

endmodule
